// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side bundle between an upstream byte FIFO and fifo_uart_tx.
// master = UART reader, slave = FIFO.
interface fifo_uart_tx_if;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd_en;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd_en
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_rd_en
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains bytes from an upstream FIFO.
// 8 data bits LSB first, optional even parity, one stop bit.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    fifo_uart_tx_if.master        fifo,
    output logic                  tx,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           frame_count
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          par_q, par_d;
    logic          tx_q, tx_d;
    logic [15:0]   fc_q;
    logic          rd_c;
    logic          done_c;
    logic          last;

    assign last = (cnt_q == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            if (done_c)
                fc_q <= fc_q + 16'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        rd_c    = 1'b0;
        done_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (enable && !fifo.fifo_empty) begin
                    rd_c    = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // Data is valid the cycle after the read strobe.
                sh_d    = fifo.fifo_data;
                par_d   = ^fifo.fifo_data;
                cnt_d   = '0;
                state_d = START;
            end
            START: begin
                if (last) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (last) begin
                    cnt_d = '0;
                    sh_d  = {1'b0, sh_q[7:1]};
                    if (bit_q == 3'd7)
                        state_d = PARITY_EN ? PARITY : STOP;
                    else
                        bit_d = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PARITY: begin
                if (last) begin
                    cnt_d   = '0;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (last) begin
                    cnt_d   = '0;
                    done_c  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // tx is registered from the next state so the line never glitches.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = sh_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    assign fifo.fifo_rd_en = rd_c & ~reset;
    assign done            = done_c & ~reset;
    assign tx              = tx_q;
    assign busy            = (state_q != IDLE);
    assign frame_count     = fc_q;

endmodule
